// File: rtl/hearts_pkg.sv
// Shared definitions for the player hearts / invincibility controller:
// state encoding and default tuning values.
package hearts_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    INV   = 2'd1,
    DEAD  = 2'd2
  } hearts_state_t;

  localparam int DEF_MAX_HEARTS   = 3;
  localparam int DEF_INV_FRAMES   = 120;
  localparam int DEF_BLINK_FRAMES = 8;

endpackage

// File: rtl/hearts_ctrl_frame_timer.sv
// 8-bit loadable down-counter advanced by frame ticks; holds at zero and
// reports it through the zero flag.
module frame_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] count;

  // Clear wins over load, load wins over a tick; a tick at zero is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/hearts_ctrl.sv
// Player hearts controller: hit/heal bookkeeping, post-hit invincibility
// window with sprite blinking, and game-over handling.
import hearts_pkg::*;

module hearts_ctrl #(
  parameter int MAX_HEARTS   = DEF_MAX_HEARTS,
  parameter int INV_FRAMES   = DEF_INV_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       heal,
  input  logic       new_game,
  output logic [1:0] num_hearts,
  output logic       hearts_visible,
  output logic       invincible,
  output logic       game_over
);

  localparam logic [1:0] MAX_H      = 2'(MAX_HEARTS);
  localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  hearts_state_t state, state_n;
  logic [1:0]    hearts_n;
  logic [7:0]    blink_count, blink_n;
  logic          visible_n;
  logic          timer_clear, timer_load, timer_tick, timer_zero;

  frame_timer u_inv_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (timer_clear),
    .load       (timer_load),
    .load_value (INV_LOAD),
    .tick       (timer_tick),
    .zero       (timer_zero)
  );

  assign timer_tick = frame_tick && (state == INV) && !new_game;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ALIVE;
      num_hearts     <= MAX_H;
      blink_count    <= 8'd0;
      hearts_visible <= 1'b1;
      invincible     <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state          <= state_n;
      num_hearts     <= hearts_n;
      blink_count    <= blink_n;
      hearts_visible <= visible_n;
      invincible     <= (state_n == INV);
      game_over      <= (state_n == DEAD);
    end
  end

  // new_game overrides everything; a hit acted on in ALIVE swallows any heal.
  always_comb begin
    state_n     = state;
    hearts_n    = num_hearts;
    blink_n     = blink_count;
    visible_n   = hearts_visible;
    timer_clear = 1'b0;
    timer_load  = 1'b0;

    if (new_game) begin
      state_n     = ALIVE;
      hearts_n    = MAX_H;
      blink_n     = 8'd0;
      visible_n   = 1'b1;
      timer_clear = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          visible_n = 1'b1;
          if (hit) begin
            if (num_hearts > 2'd1) begin
              hearts_n   = num_hearts - 2'd1;
              state_n    = INV;
              timer_load = 1'b1;
              blink_n    = 8'd0;
            end else begin
              hearts_n = 2'd0;
              state_n  = DEAD;
            end
          end else if (heal && (num_hearts < MAX_H)) begin
            hearts_n = num_hearts + 2'd1;
          end
        end

        INV: begin
          if (heal && (num_hearts < MAX_H)) begin
            hearts_n = num_hearts + 2'd1;
          end
          // The timer reached zero on an earlier tick; leave INV now.
          if (timer_zero) begin
            state_n   = ALIVE;
            blink_n   = 8'd0;
            visible_n = 1'b1;
          end else if (frame_tick) begin
            if (blink_count == BLINK_LAST) begin
              blink_n   = 8'd0;
              visible_n = !hearts_visible;
            end else begin
              blink_n = blink_count + 8'd1;
            end
          end
        end

        DEAD: begin
          hearts_n  = 2'd0;
          visible_n = 1'b1;
        end

        default: begin
          state_n   = ALIVE;
          blink_n   = 8'd0;
          visible_n = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hearts_ctrl.sv
// Self-checking bench for hearts_ctrl: a tick-counting reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_hearts_ctrl;

  localparam int MAX_H = 3;
  localparam int INV_F = 120;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick, hit, heal, new_game;
  logic [1:0] num_hearts;
  logic       hearts_visible, invincible, game_over;

  int checks   = 0;
  int failures = 0;

  // Reference model: state, heart count, frames left, ticks since INV entry.
  int m_state;
  int m_hearts;
  int m_frames;
  int m_ticks;

  hearts_ctrl #(
    .MAX_HEARTS   (MAX_H),
    .INV_FRAMES   (INV_F),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .hit            (hit),
    .heal           (heal),
    .new_game       (new_game),
    .num_hearts     (num_hearts),
    .hearts_visible (hearts_visible),
    .invincible     (invincible),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  // Model states: 0 alive, 1 invincible, 2 dead.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state  = 0;
      m_hearts = MAX_H;
      m_frames = 0;
      m_ticks  = 0;
    end else if (new_game) begin
      m_state  = 0;
      m_hearts = MAX_H;
      m_frames = 0;
      m_ticks  = 0;
    end else if (m_state == 0) begin
      if (hit) begin
        if (m_hearts > 1) begin
          m_hearts = m_hearts - 1;
          m_state  = 1;
          m_frames = INV_F;
          m_ticks  = 0;
        end else begin
          m_hearts = 0;
          m_state  = 2;
        end
      end else if (heal) begin
        m_hearts = (m_hearts + 1 > MAX_H) ? MAX_H : m_hearts + 1;
      end
    end else if (m_state == 1) begin
      if (heal) m_hearts = (m_hearts + 1 > MAX_H) ? MAX_H : m_hearts + 1;
      if (m_frames == 0) begin
        m_state = 0;
        m_ticks = 0;
      end else if (frame_tick) begin
        m_frames = m_frames - 1;
        m_ticks  = m_ticks + 1;
      end
    end
  end

  task automatic compare_model();
    logic [4:0] got, exp;
    logic       exp_vis;
    exp_vis = (m_state != 1) || (((m_ticks / BLINK) % 2) == 0);
    exp = {2'(m_hearts), exp_vis, (m_state == 1), (m_state == 2)};
    got = {num_hearts, hearts_visible, invincible, game_over};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL model t=%0t got hearts/vis/inv/go=%b required=%b", $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_model();
  endtask

  task automatic apply_stimulus(input logic h, input logic hl, input logic ng,
                                input logic ft, input int n);
    hit        = h;
    heal       = hl;
    new_game   = ng;
    frame_tick = ft;
    repeat (n) cyc();
    heal       = 1'b0;
    new_game   = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic run_frames(input int n, input logic hold_hit);
    for (int t = 0; t < n; t++) begin
      apply_stimulus(hold_hit, 1'b0, 1'b0, 1'b1, 1);
      apply_stimulus(hold_hit, 1'b0, 1'b0, 1'b0, 1);
    end
  endtask

  task automatic check_output(input string name, input int e_hearts, input logic e_vis,
                              input logic e_inv, input logic e_go);
    checks++;
    if (num_hearts !== 2'(e_hearts) || hearts_visible !== e_vis ||
        invincible !== e_inv || game_over !== e_go) begin
      failures++;
      $display("[TB] FAIL %s got %0d/%b/%b/%b required %0d/%b/%b/%b", name,
               num_hearts, hearts_visible, invincible, game_over,
               e_hearts, e_vis, e_inv, e_go);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    hit        = 1'b0;
    heal       = 1'b0;
    new_game   = 1'b0;
    frame_tick = 1'b0;
    repeat (2) cyc();
    check_output("reset", 3, 1, 0, 0);
    reset_n = 1'b1;
    cyc();

    // Held hit costs exactly one heart.
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("hit_entry", 2, 1, 1, 0);
    apply_stimulus(1, 0, 0, 0, 9);
    check_output("hit_held", 2, 1, 1, 0);
    hit = 1'b0;

    // Blink phase and window length.
    run_frames(7, 0);
    check_output("blink_t7", 2, 1, 1, 0);
    run_frames(1, 0);
    check_output("blink_t8", 2, 0, 1, 0);
    run_frames(8, 0);
    check_output("blink_t16", 2, 1, 1, 0);
    run_frames(104, 0);
    check_output("inv_exit", 2, 1, 0, 0);
    run_frames(3, 0);
    check_output("tick_alive", 2, 1, 0, 0);

    // Hit and heal together: heal dropped; heal in INV counts.
    apply_stimulus(1, 1, 0, 0, 1);
    hit = 1'b0;
    check_output("hit_heal", 1, 1, 1, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    check_output("heal_inv", 2, 1, 1, 0);
    run_frames(120, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 1);
    check_output("heal_sat", 3, 1, 0, 0);

    // Hit held through the whole window re-hits on the first ALIVE cycle.
    apply_stimulus(1, 0, 0, 0, 1);
    run_frames(120, 1);
    check_output("rehit_alive", 2, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("rehit", 1, 1, 1, 0);
    hit = 1'b0;
    run_frames(120, 0);

    // Death and restart.
    apply_stimulus(1, 0, 0, 0, 1);
    hit = 1'b0;
    check_output("dead", 0, 1, 0, 1);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(1, 0, 0, 0, 1);
    hit = 1'b0;
    apply_stimulus(0, 0, 0, 1, 1);
    check_output("dead_hold", 0, 1, 0, 1);
    apply_stimulus(0, 0, 1, 0, 1);
    check_output("new_game", 3, 1, 0, 0);

    // new_game beats a simultaneous hit and aborts INV.
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(1, 0, 1, 0, 1);
    hit = 1'b0;
    check_output("new_game_inv", 3, 1, 0, 0);

    // Asynchronous reset in the middle of INV.
    apply_stimulus(1, 0, 0, 0, 1);
    hit = 1'b0;
    run_frames(50, 0);
    check_output("pre_reset", 2, 1, 1, 0);
    reset_n = 1'b0;
    #1;
    check_output("async_reset", 3, 1, 0, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    run_frames(20, 0);
    check_output("post_reset", 3, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
